// File: rtl/present_byte_io.sv
// Byte-serial load/run/drain front end for a round-based PRESENT-80 core.
// Streams in key+plaintext, runs the core under a watchdog, streams out ciphertext.
module present_byte_io #(
  parameter int WATCHDOG = 63
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] core_key,
  output logic [63:0] core_plaintext,
  output logic        core_n_reset,
  input  logic        core_done,
  input  logic [63:0] core_ciphertext,
  output logic        busy,
  output logic        error
);

  localparam int WDW = $clog2(WATCHDOG + 1);
  localparam logic [WDW-1:0] WD_LIM = WDW'(WATCHDOG - 1);
  localparam logic [WDW-1:0] WD_MAX = {WDW{1'b1}};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [79:0]     key_q, key_d;
  logic [63:0]     pt_q, pt_d;
  logic [63:0]     shift_q, shift_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    key_d   = key_q;
    pt_d    = pt_q;
    shift_d = shift_q;
    err_d   = err_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (cnt_q < 5'd10) begin
            key_d = {key_q[71:0], in_data};
          end else begin
            pt_d = {pt_q[55:0], in_data};
          end
          if (cnt_q == 5'd0) begin
            err_d = 1'b0;
          end
          if (cnt_q == 5'd17) begin
            cnt_d   = 5'd0;
            wd_d    = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      RUN: begin
        // core_done has priority over the watchdog limit
        if (core_done) begin
          shift_d = core_ciphertext;
          wd_d    = '0;
          state_d = DRAIN;
        end else if (wd_q == WD_LIM) begin
          err_d   = 1'b1;
          wd_d    = '0;
          state_d = LOAD;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          shift_d = {shift_q[55:0], 8'h00};
          if (cnt_q == 5'd7) begin
            cnt_d   = 5'd0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      wd_q    <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      shift_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      shift_q <= shift_d;
      err_q   <= err_d;
    end
  end

  assign in_ready       = (state_q == LOAD);
  assign out_valid      = (state_q == DRAIN);
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign core_n_reset   = (state_q == RUN);
  assign out_data       = shift_q[63:56];
  assign core_key       = key_q;
  assign core_plaintext = pt_q;
  assign error          = err_q;

endmodule

// File: doc/present_byte_io.md
# present_byte_io

Byte-serial host front end for the round-based PRESENT-80 encryption core. It assembles an 80-bit key and a 64-bit plaintext from an 8-bit valid/ready input stream. It releases the core from reset to run one encryption and waits for the core's done flag. It then returns the 64-bit ciphertext as eight bytes on a valid/ready output stream. The block sits directly upstream and downstream of the core, and drives the core's reset, key and plaintext inputs.

## Interface
- WATCHDOG, default 63: maximum number of cycles spent in RUN before the encryption is aborted.
- clk  in  1  system clock, rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- in_data  in  8  host input byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- out_data  out  8  ciphertext byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host accepts out_data.
- core_key  out  80  key to the core.
- core_plaintext  out  64  plaintext to the core.
- core_n_reset  out  1  active-low reset to the core.
- core_done  in  1  core finished; level-sensitive.
- core_ciphertext  in  64  core result; valid while core_done=1.
- busy  out  1  high in RUN and DRAIN.
- error  out  1  sticky watchdog-abort flag.

## Operation
- The FSM has three states: LOAD, RUN and DRAIN. The reset state is LOAD.
- LOAD:
  - in_ready=1. A byte is accepted on a cycle where in_valid&&in_ready.
  - A 5-bit byte counter runs 0..17.
  - Bytes 0-9 form the key, MSB byte first. Each accepted byte shifts into core_key[7:0] while the rest shifts left.
  - Bytes 10-17 form the plaintext, MSB byte first, shifted into core_plaintext the same way.
  - Accepting byte 17 clears the counter and moves the FSM to RUN.
  - Accepting byte 0 clears error.
- RUN:
  - in_ready=0. The watchdog counter starts at 0 and increments every cycle.
  - If core_done=1, core_ciphertext is latched into the 64-bit output shift register and the FSM moves to DRAIN.
  - Otherwise, if the watchdog counter equals WATCHDOG-1, error is set and the FSM moves to LOAD. No output is produced.
  - If both conditions hold on the same cycle, core_done wins.
- DRAIN:
  - out_valid=1 and out_data=shift[63:56].
  - On each cycle with out_valid&&out_ready, the register shifts left 8 and the byte counter increments.
  - The 8th handshake returns the FSM to LOAD and clears the counter.
- core_n_reset=1 only while the state is RUN. In every other state the core is held in reset, which clears its done flag and round counter.
- core_done is ignored outside RUN.
- core_key and core_plaintext change only in LOAD and hold their values through RUN. A new block requires all 18 bytes to be resent; the key is never retained implicitly.
- The watchdog counter is $clog2(WATCHDOG+1) bits wide and saturates.
- in_ready, out_valid, busy and core_n_reset are decoded from the state register only; no input feeds them combinationally.

## Timing
- Reset values:
  - State LOAD, in_ready=1, out_valid=0, out_data=0.
  - core_n_reset=0, core_key=0, core_plaintext=0.
  - busy=0, error=0, and all counters 0.
- Reset asserted at any time, including mid-RUN or mid-DRAIN, applies these values immediately. Partial input and undelivered ciphertext are discarded.
- Last input byte accepted at edge k: state=RUN and core_n_reset=1 from edge k. The core's first clock edge out of reset is k+1.
- core_done sampled high at edge m: out_valid=1 from edge m. The first byte is on out_data in the same cycle; the latch-to-valid latency is 1 cycle.
- Each input or output byte needs exactly one cycle with both valid and ready high.
- Peak throughput is 18 input cycles + core latency + 8 output cycles per block.
- out_data and out_valid stay stable while out_ready=0.
- in_valid during RUN or DRAIN is not accepted and must be held by the host.

## Test plan
- Key=00…00, pt=0000000000000000, out_ready=1 with the real core: out_data = 55,79,C1,38,7B,22,84,45. error=0, and busy drops the cycle after the 8th output byte.
- Key=FF…FF, pt=0000000000000000: output E7,2C,46,C0,F5,94,50,49. Then send key=00…00, pt=FFFFFFFFFFFFFFFF back-to-back: output A1,12,FF,C7,2F,68,41,7B.
- Random in_valid and out_ready gaps (≈50%) on the first vector:
  - The same 8 bytes are produced.
  - out_data stays stable while stalled.
  - in_ready=0 from the 18th accept until the 8th output handshake.
- Stub core with core_done tied to 0 and WATCHDOG=63: exactly 63 RUN cycles, then error=1, state LOAD, out_valid never high. The next byte 0 accepted clears error.
- Stub core with core_done asserted on the first RUN cycle together with the watchdog limit (WATCHDOG=1): the ciphertext is captured and error stays 0.
- n_reset pulsed low mid-RUN and again after the 3rd output byte:
  - All outputs return to reset values within the reset pulse.
  - The next full 18-byte load yields the correct ciphertext.
